// File: rtl/ps2_key_gen.sv
// ps2_key_gen: host-side PS/2 keyboard receiver producing the 11-bit ps2_key
// event word {toggle, pressed, extended, scancode}.
//
// Ports:
//   clk_sys      in   system clock (only clock)
//   reset        in   synchronous active-high reset
//   ps2_clk      in   raw PS/2 clock (asynchronous)
//   ps2_data     in   raw PS/2 data (asynchronous)
//   ps2_key      out  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   ps2_key_stb  out  one-cycle pulse with each ps2_key update
//   frame_err    out  one-cycle pulse per dropped frame
//
// Build option: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity;
// otherwise the parity bit is sampled and ignored.
module ps2_key_gen #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 96000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        ps2_key_stb,
    output logic        frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    typedef enum logic {
        S_IDLE       = 1'b0,
        S_PAUSE_SKIP = 1'b1
    } state_t;

    // Input synchronisers and glitch filter
    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_c;

    // Frame receiver
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_rdy_c;
    logic          rx_err_c;

    // Decoder
    state_t        state_q, state_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   key_q, key_d;
    logic          stb_q, stb_d;
    logic          err_q, err_d;

    // Two-flop synchronisers; idle level of both lines is high
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Filtered clock flips after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_cnt_d = '0;
        filt_clk_d = filt_clk_q;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall_c = filt_clk_q & ~filt_clk_d;

    // Bit counter, shift register, parity capture and inter-bit timeout
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        byte_rdy_c = 1'b0;
        rx_err_c   = 1'b0;
        if (fall_c) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd0) begin
                // A high start bit is dropped without leaving bit 0
                if (data_s2_q) begin
                    rx_err_c = 1'b1;
                end else begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {data_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                par_d     = data_s2_q;
                bit_cnt_d = 4'd10;
            end else begin
                bit_cnt_d = 4'd0;
                if (!data_s2_q) begin
                    rx_err_c = 1'b1;
                end else if (PAR_CHECK && (par_q != ~^shift_q)) begin
                    rx_err_c = 1'b1;
                end else begin
                    byte_rdy_c = 1'b1;
                end
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d = 4'd0;
                tmo_d     = '0;
                rx_err_c  = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Decoder next state: prefix flags, Pause skipping, housekeeping filter
    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        skip_d  = skip_q;
        key_d   = key_q;
        stb_d   = 1'b0;
        err_d   = rx_err_c;
        if (byte_rdy_c) begin
            case (state_q)
                S_IDLE: begin
                    if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q == 8'hE1) begin
                        state_d = S_PAUSE_SKIP;
                        skip_d  = 3'd7;
                    end else if (!ext_q && !brk_q &&
                                 (shift_q == 8'hAA || shift_q == 8'hFA ||
                                  shift_q == 8'hFE || shift_q == 8'hEE ||
                                  shift_q == 8'h00 || shift_q == 8'hFF)) begin
                        stb_d = 1'b0;
                    end else begin
                        key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
                        stb_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                S_PAUSE_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            state_q    <= S_IDLE;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= 3'd0;
            key_q      <= 11'h000;
            stb_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            key_q      <= key_d;
            stb_q      <= stb_d;
            err_q      <= err_d;
        end
    end

    assign ps2_key     = key_q;
    assign ps2_key_stb = stb_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_ps2_key_gen.sv
// tb_ps2_key_gen: directed testbench for ps2_key_gen. Drives PS/2 frames at a
// shortened bit period and a shortened timeout, and checks event words,
// strobe counts and frame_err counts against hand-computed values.
module tb_ps2_key_gen;

    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 2000;
    localparam int          HALF        = 40;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        ps2_key_stb;
    logic        frame_err;

    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    int          stb_cnt = 0;
    int          err_cnt = 0;
    logic [10:0] last_key = 11'h000;
    int          stb_base;
    int          err_base;

    ps2_key_gen #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_key    (ps2_key),
        .ps2_key_stb(ps2_key_stb),
        .frame_err  (frame_err)
    );

    always #10 clk_sys = ~clk_sys;

    // Event monitor, sampled on the inactive edge
    always @(negedge clk_sys) begin
        if (ps2_key_stb) begin
            stb_cnt  = stb_cnt + 1;
            last_key = ps2_key;
        end
        if (frame_err) begin
            err_cnt = err_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0, 1'b1), 11);
        wait_cyc(HALF);
    endtask

    task automatic mark;
        stb_base = stb_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        wait_cyc(5);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_stb", 32'(ps2_key_stb), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        wait_cyc(10);

        // Simple make / break
        mark();
        send_byte(8'h29);
        check("make_29_key", 32'(last_key), 32'h629);
        send_byte(8'hF0);
        send_byte(8'h29);
        check("break_29_key", 32'(last_key), 32'h029);
        check("make_break_stb", 32'(stb_cnt - stb_base), 32'd2);
        check("make_break_held", 32'(ps2_key), 32'h029);

        // Extended make / break
        mark();
        send_byte(8'hE0);
        send_byte(8'h6B);
        check("ext_make_key", 32'(last_key), 32'h76B);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        check("ext_break_key", 32'(last_key), 32'h16B);
        check("ext_stb", 32'(stb_cnt - stb_base), 32'd2);

        // Wrong parity on 29
        mark();
        send_bits(frame(8'h29, 1'b1, 1'b1), 11);
        wait_cyc(HALF);
        check("badpar_stb", 32'(stb_cnt - stb_base), PAR ? 32'd0 : 32'd1);
        check("badpar_err", 32'(err_cnt - err_base), PAR ? 32'd1 : 32'd0);
        check("badpar_key", 32'(ps2_key), PAR ? 32'h16B : 32'h629);

        // Stop bit low
        mark();
        send_bits(frame(8'h29, 1'b0, 1'b0), 11);
        wait_cyc(HALF);
        check("badstop_err", 32'(err_cnt - err_base), 32'd1);
        check("badstop_stb", 32'(stb_cnt - stb_base), 32'd0);

        // Timeout after 5 bits, then a clean frame
        mark();
        send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
        wait_cyc(TIMEOUT_CYC + 100);
        check("timeout_err", 32'(err_cnt - err_base), 32'd1);
        check("timeout_stb", 32'(stb_cnt - stb_base), 32'd0);
        send_byte(8'h1C);
        check("after_timeout_key", 32'(last_key), PAR ? 32'h61C : 32'h21C);

        // 3-cycle low glitch on idle clock
        mark();
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(50);
        check("glitch_err", 32'(err_cnt - err_base), 32'd0);
        check("glitch_stb", 32'(stb_cnt - stb_base), 32'd0);

        // Pause sequence followed by 16
        mark();
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        check("pause_no_event", 32'(stb_cnt - stb_base), 32'd0);
        send_byte(8'h16);
        check("pause_then_16_stb", 32'(stb_cnt - stb_base), 32'd1);
        check("pause_then_16_key", 32'(last_key), PAR ? 32'h216 : 32'h616);

        // Housekeeping bytes
        mark();
        send_byte(8'hAA);
        send_byte(8'hFA);
        check("housekeeping_stb", 32'(stb_cnt - stb_base), 32'd0);
        check("housekeeping_key", 32'(ps2_key), PAR ? 32'h216 : 32'h616);

        // Reset mid-frame
        send_bits(frame(8'h33, 1'b0, 1'b1), 6);
        reset = 1'b1;
        wait_cyc(1);
        check("midreset_key", 32'(ps2_key), 32'h000);
        check("midreset_stb", 32'(ps2_key_stb), 32'h0);
        check("midreset_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        wait_cyc(10);
        mark();
        send_byte(8'h05);
        check("after_reset_key", 32'(last_key), 32'h605);
        check("after_reset_stb", 32'(stb_cnt - stb_base), 32'd1);
        check("after_reset_err", 32'(err_cnt - err_base), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
